// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: requester drives start/a/b/cin,
// adder returns busy/done/sum/cout.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Handshake: start is taken on a rising edge whenever busy = 0 (IDLE or the
  // DONE cycle), capturing a/b/cin on that edge; start while busy is dropped.
  // done is a one-cycle pulse, and sum/cout are valid from that cycle on.
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a registered carry adds two
// WIDTH-bit operands LSB first over WIDTH cycles.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus,
  output logic [1:0]     o_dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_s_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_fa_s;
  logic             w_fa_co;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_s_cat;
  logic [WIDTH-1:0] w_s_shift;

  // Full-adder cell on the current LSB pair and the looped-back carry.
  assign w_fa_s    = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
  assign w_fa_co   = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) | (r_b_sr[0] & r_carry);
  assign w_accept  = bus.start && (r_state != S_RUN);
  assign w_last    = (r_state == S_RUN) && (r_cnt == LAST);
  // Sum bit enters at the MSB; concatenation form stays legal for WIDTH = 1.
  assign w_s_cat   = {w_fa_s, r_s_sr};
  assign w_s_shift = w_s_cat[WIDTH:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (r_state == S_RUN);
    bus.done    = (r_state == S_DONE);
    bus.sum     = r_sum;
    bus.cout    = r_cout;
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a_sr  <= bus.a;
      r_b_sr  <= bus.b;
      r_carry <= bus.cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sr  <= r_a_sr >> 1;
      r_b_sr  <= r_b_sr >> 1;
      r_s_sr  <= w_s_shift;
      r_carry <= w_fa_co;
      r_cnt   <= r_cnt + CW'(1);
      // Result registers move only here so they hold through later operations.
      if (w_last) begin
        r_sum  <= w_s_shift;
        r_cout <= w_fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 and WIDTH=1 instances, cycle-exact
// busy/done checks and a queue of expected {cout,sum} results.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg8;
  logic [1:0] dbg1;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave), .o_dbg_state(dbg8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave), .o_dbg_state(dbg1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic sb_pop(input string tag);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected_done"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_sum"}, 32'(if8.sum), 32'(e[7:0]));
      chk({tag, "_cout"}, 32'(if8.cout), 32'(e[8]));
    end
  endtask

  // Called at a falling edge; start is high across the next rising edge (cycle N).
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
    if8.a = a; if8.b = b; if8.cin = c; if8.start = 1'b1;
    exp_q.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk({tag, "_busy"}, 32'(if8.busy), 32'(i <= 8));
      chk({tag, "_done"}, 32'(if8.done), 32'(i == 9));
      if (if8.done) sb_pop(tag);
      if (i == 1) begin
        if8.start = 1'b0;
        if8.a = 8'($urandom_range(0, 255));
        if8.b = 8'($urandom_range(0, 255));
        if8.cin = 1'($urandom_range(0, 1));
      end
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic op1(input logic a, input logic b, input logic c, input string tag);
    logic [1:0] e;
    e = {1'b0, a} + {1'b0, b} + {1'b0, c};
    if1.a = a; if1.b = b; if1.cin = c; if1.start = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) if1.start = 1'b0;
      chk({tag, "_busy"}, 32'(if1.busy), 32'(i == 1));
      chk({tag, "_done"}, 32'(if1.done), 32'(i == 2));
      if (i == 2) begin
        chk({tag, "_sum"}, 32'(if1.sum), 32'(e[0]));
        chk({tag, "_cout"}, 32'(if1.cout), 32'(e[1]));
      end
    end
  endtask

  initial begin
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(if8.busy), 32'd0);
    chk("rst_done", 32'(if8.done), 32'd0);
    chk("rst_sum", 32'(if8.sum), 32'd0);
    chk("rst_cout", 32'(if8.cout), 32'd0);
    chk("rst_state", 32'(dbg8), 32'd0);
    chk("rst_busy1", 32'(if1.busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op8(8'h5A, 8'h33, 1'b0, "basic");
    op8(8'hFF, 8'h01, 1'b0, "ripple1");
    op8(8'hFF, 8'hFF, 1'b1, "ripple2");

    // start during busy: second request in cycle N+3 must be ignored
    if8.a = 8'h10; if8.b = 8'h20; if8.cin = 1'b0; if8.start = 1'b1;
    exp_q.push_back(9'h030);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("busyreq_busy", 32'(if8.busy), 32'(i <= 8));
      chk("busyreq_done", 32'(if8.done), 32'(i == 9));
      if (if8.done) sb_pop("busyreq");
      if (i == 1) if8.start = 1'b0;
      if (i == 3) begin if8.a = 8'hAA; if8.b = 8'hAA; if8.start = 1'b1; end
      if (i == 4) if8.start = 1'b0;
    end
    chk("busyreq_drained", 32'(exp_q.size()), 32'd0);

    // back-to-back with start held through the DONE cycle
    if8.a = 8'h01; if8.b = 8'h01; if8.cin = 1'b0; if8.start = 1'b1;
    exp_q.push_back(9'h002);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("b2b_busy", 32'(if8.busy), 32'((i <= 8) || (i >= 10 && i <= 17)));
      chk("b2b_done", 32'(if8.done), 32'(i == 9 || i == 18));
      if (if8.done) sb_pop("b2b");
      if (i >= 10 && i <= 17) chk("b2b_hold", 32'(if8.sum), 32'h02);
      if (i == 1) begin if8.a = 8'h80; if8.b = 8'h80; end
      if (i == 9) exp_q.push_back(9'h100);
      if (i == 10) if8.start = 1'b0;
    end
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);

    // asynchronous reset in the middle of cycle N+4
    if8.a = 8'h55; if8.b = 8'h66; if8.cin = 1'b1; if8.start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) if8.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(if8.busy), 32'd0);
    chk("arst_done", 32'(if8.done), 32'd0);
    chk("arst_sum", 32'(if8.sum), 32'd0);
    chk("arst_cout", 32'(if8.cout), 32'd0);
    chk("arst_state", 32'(dbg8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("arst_no_done", 32'(if8.done), 32'd0);
    end
    op8(8'h03, 8'h04, 1'b0, "post_rst");

    repeat (4) op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), "rand");

    op1(1'b1, 1'b1, 1'b1, "w1_111");
    op1(1'b0, 1'b1, 1'b0, "w1_010");
    op1(1'b1, 1'b0, 1'b1, "w1_101");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
